// File: rtl/vip_stream_pkg.sv
// Shared types and constants for the Avalon-ST Video (VIP) stream adapters.
// ctrl_nibble() maps a control-packet beat index to the field nibble it carries.
package vip_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CTRL_HDR,
      CTRL_BODY,
      DATA_HDR,
      DATA
   } state_t;

   localparam logic [3:0] VIP_TYPE_CTRL  = 4'hF;
   localparam logic [3:0] VIP_TYPE_VIDEO = 4'h0;
   localparam int         CTRL_BEATS     = 9;

   // Width and height go out most-significant nibble first, then interlace.
   function automatic logic [3:0] ctrl_nibble(
      input logic [3:0]  k,
      input logic [15:0] w,
      input logic [15:0] h,
      input logic [3:0]  il
   );
      logic [3:0] nib;
      case (k)
         4'd0:    nib = w[15:12];
         4'd1:    nib = w[11:8];
         4'd2:    nib = w[7:4];
         4'd3:    nib = w[3:0];
         4'd4:    nib = h[15:12];
         4'd5:    nib = h[11:8];
         4'd6:    nib = h[7:4];
         4'd7:    nib = h[3:0];
         4'd8:    nib = il;
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/vip_st_out_reg.sv
// Single-stage Avalon-ST output register (readyLatency 0).
// The register takes a new beat whenever it is empty or its current beat is being accepted.
module vip_st_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              beat_valid,
   input  logic [DATA_W-1:0] beat_data,
   input  logic              beat_sop,
   input  logic              beat_eop,
   output logic              load,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_sop,
   output logic              dout_eop
);

   assign load = !dout_valid | dout_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_sop   <= 1'b0;
         dout_eop   <= 1'b0;
      end else if (load) begin
         dout_valid <= beat_valid;
         // Payload only moves with a real beat; an empty slot keeps the last value.
         if (beat_valid) begin
            dout_data <= beat_data;
            dout_sop  <= beat_sop;
            dout_eop  <= beat_eop;
         end
      end
   end

endmodule

// File: rtl/fifo_to_vip_stream.sv
// Drains a show-ahead pixel FIFO into an Avalon-ST Video stream: one control packet
// (WIDTH/HEIGHT/INTERLACE) followed by one video packet per frame.
module fifo_to_vip_stream
   import vip_stream_pkg::*;
#(
   parameter int         WIDTH     = 1280,
   parameter int         HEIGHT    = 720,
   parameter logic [3:0] INTERLACE = 4'h0
) (
   input  logic       clock,
   input  logic       reset,
   output logic       in_rd_en,
   input  logic       in_empty,
   input  logic [7:0] in_dout,
   output logic [7:0] dout_data,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       dout_sop,
   output logic       dout_eop,
   output logic       frame_done
);

   localparam int              COL_W     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int              ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
   localparam logic [15:0]      WIDTH16   = 16'(WIDTH);
   localparam logic [15:0]      HEIGHT16  = 16'(HEIGHT);
   localparam logic [3:0]       CTRL_LAST = 4'(CTRL_BEATS - 1);

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [COL_W-1:0] col_reg, col_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic             vid_eop_reg;
   logic             frame_done_reg;

   logic             load;
   logic             beat_valid;
   logic [7:0]       beat_data;
   logic             beat_sop;
   logic             beat_eop;
   logic             beat_vid_eop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      col_next     = col_reg;
      row_next     = row_reg;
      beat_valid   = 1'b0;
      beat_data    = 8'h00;
      beat_sop     = 1'b0;
      beat_eop     = 1'b0;
      beat_vid_eop = 1'b0;
      in_rd_en     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (!in_empty)
               state_next = CTRL_HDR;
         end
         CTRL_HDR: begin
            if (load) begin
               beat_valid = 1'b1;
               beat_data  = {4'h0, VIP_TYPE_CTRL};
               beat_sop   = 1'b1;
               cnt_next   = '0;
               state_next = CTRL_BODY;
            end
         end
         CTRL_BODY: begin
            if (load) begin
               beat_valid = 1'b1;
               beat_data  = {4'h0, ctrl_nibble(cnt_reg, WIDTH16, HEIGHT16, INTERLACE)};
               if (cnt_reg == CTRL_LAST) begin
                  beat_eop   = 1'b1;
                  state_next = DATA_HDR;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end
         end
         DATA_HDR: begin
            if (load) begin
               beat_valid = 1'b1;
               beat_data  = {4'h0, VIP_TYPE_VIDEO};
               beat_sop   = 1'b1;
               col_next   = '0;
               row_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            // Pop only when the output register can take the pixel this very cycle.
            in_rd_en = load & !in_empty;
            if (in_rd_en) begin
               beat_valid = 1'b1;
               beat_data  = in_dout;
               if (col_reg == COL_LAST) begin
                  col_next = '0;
                  if (row_reg == ROW_LAST) begin
                     beat_eop     = 1'b1;
                     beat_vid_eop = 1'b1;
                     row_next     = '0;
                     state_next   = IDLE;
                  end else begin
                     row_next = row_reg + 1'b1;
                  end
               end else begin
                  col_next = col_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   vip_st_out_reg #(
      .DATA_W (8)
   ) u_out_reg (
      .clock      (clock),
      .reset      (reset),
      .beat_valid (beat_valid),
      .beat_data  (beat_data),
      .beat_sop   (beat_sop),
      .beat_eop   (beat_eop),
      .load       (load),
      .dout_data  (dout_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_sop   (dout_sop),
      .dout_eop   (dout_eop)
   );

   // Tags the held beat as the video EOP so frame_done ignores the control-packet EOP.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vid_eop_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         if (load)
            vid_eop_reg <= beat_vid_eop;
         frame_done_reg <= dout_valid & dout_ready & vid_eop_reg;
      end
   end

   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_fifo_to_vip_stream.sv
// Scoreboard bench for fifo_to_vip_stream: a queue-based FIFO model feeds the DUT,
// expected beats are built from the frame format and checked by an independent monitor.
module tb_fifo_to_vip_stream;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int NP = W * H;

   typedef struct {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       vid_eop;
   } beat_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_rd_en, in_empty = 1'b1;
   logic [7:0] in_dout = 8'h00;
   logic [7:0] dout_data;
   logic       dout_valid, dout_ready = 1'b0, dout_sop, dout_eop, frame_done;

   logic       def_rd_en, def_valid, def_sop, def_eop, def_fd;
   logic [7:0] def_data;

   int n_cmp = 0;
   int n_err = 0;

   beat_t      sb_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] pend_q[$];
   int  cyc = 0, pop_cnt = 0, acc_cnt = 0, fd_cnt = 0, def_seen = 0;
   int  ready_mode = 0, gap_mode = 0;
   logic pop_seen = 1'b0;

   always #5 clock = ~clock;

   fifo_to_vip_stream #(.WIDTH(W), .HEIGHT(H), .INTERLACE(4'h0)) dut (
      .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
      .in_dout(in_dout), .dout_data(dout_data), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop),
      .frame_done(frame_done)
   );

   // Default-parameter instance: only its control packet is examined.
   fifo_to_vip_stream u_def (
      .clock(clock), .reset(reset), .in_rd_en(def_rd_en), .in_empty(1'b0),
      .in_dout(8'hA5), .dout_data(def_data), .dout_valid(def_valid),
      .dout_ready(1'b1), .dout_sop(def_sop), .dout_eop(def_eop),
      .frame_done(def_fd)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a frame is header 0x0F, nine nibbles of W/H/interlace, header 0x00, pixels.
   task automatic model_frame(input int w, input int h, input logic [7:0] pix[$]);
      int fields[9];
      fields = '{(w >> 12) % 16, (w >> 8) % 16, (w >> 4) % 16, w % 16,
                 (h >> 12) % 16, (h >> 8) % 16, (h >> 4) % 16, h % 16, 0};
      sb_q.push_back('{8'h0F, 1'b1, 1'b0, 1'b0});
      for (int k = 0; k < 9; k++)
         sb_q.push_back('{8'(fields[k]), 1'b0, k == 8, 1'b0});
      sb_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < pix.size(); i++)
         sb_q.push_back('{pix[i], 1'b0, i == pix.size() - 1, i == pix.size() - 1});
   endtask

   task automatic issue_frame(input bit seq, input int base);
      logic [7:0] pix[$];
      for (int i = 0; i < NP; i++)
         pix.push_back(seq ? 8'(base + i) : 8'($urandom_range(0, 255)));
      model_frame(W, H, pix);
      foreach (pix[i]) pend_q.push_back(pix[i]);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while ((sb_q.size() != 0 || fifo_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin
         @(negedge clock); #2;
         n++;
      end
      if (n >= 3000) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: %0d beats still expected", nm, sb_q.size());
         sb_q.delete();
      end
      repeat (3) @(negedge clock);
      #2;
   endtask

   always @(posedge clock) pop_seen <= in_rd_en & !reset;

   // FIFO model and ready driver: all input changes happen on the falling edge.
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         fifo_q.delete();
      end else begin
         if (pop_seen && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
         end
         if (gap_mode == 0) begin
            while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
         end else if ((cyc % 8) < 3 && pend_q.size() > 0) begin
            fifo_q.push_back(pend_q.pop_front());
         end
      end
      case (ready_mode)
         0:       dout_ready = 1'b1;
         1:       dout_ready = (cyc % 3 == 0);
         default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      in_empty = (fifo_q.size() == 0);
      in_dout  = in_empty ? 8'h00 : fifo_q[0];
   end

   // Monitor: compares accepted beats with the scoreboard, checks stalls, pops and frame_done.
   logic        fd_due = 1'b0, prev_stall = 1'b0;
   logic [10:0] prev_vec = '0;
   always @(negedge clock) begin
      #1;
      if (reset) begin
         fd_due     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("frame_done", 32'(frame_done), 32'(fd_due));
         if (frame_done) fd_cnt++;
         fd_due = 1'b0;
         if (prev_stall)
            chk("stall_hold", {21'd0, dout_valid, dout_sop, dout_eop, dout_data}, {21'd0, prev_vec});
         if (in_empty || (dout_valid && !dout_ready))
            chk("rd_en_blocked", 32'(in_rd_en), 32'd0);
         if (dout_valid && dout_ready) begin
            acc_cnt++;
            if (sb_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_beat: got data 0x%0h sop %0b eop %0b, none expected",
                        dout_data, dout_sop, dout_eop);
            end else begin
               beat_t e;
               e = sb_q.pop_front();
               chk("beat", {22'd0, dout_sop, dout_eop, dout_data}, {22'd0, e.sop, e.eop, e.data});
               fd_due = e.vid_eop;
            end
         end
         prev_stall = dout_valid && !dout_ready;
         prev_vec   = {1'b1, dout_sop, dout_eop, dout_data};
      end
   end

   // Default parameters: 1280 = 0x0500, 720 = 0x02D0.
   always @(negedge clock) begin
      #1;
      if (!reset && def_valid && def_seen < 10) begin
         logic [7:0] exp_tbl [10];
         exp_tbl = '{8'h0F, 8'h0, 8'h5, 8'h0, 8'h0, 8'h0, 8'h2, 8'hD, 8'h0, 8'h0};
         chk("def_ctrl", {22'd0, def_sop, def_eop, def_data},
             {22'd0, def_seen == 0, def_seen == 9, exp_tbl[def_seen]});
         def_seen++;
      end
   end

   initial begin
      int p0, f0, a0;
      repeat (3) @(negedge clock);
      #2;
      chk("reset_outputs", {20'd0, dout_valid, dout_sop, dout_eop, frame_done, in_rd_en, dout_data}, 32'd0);
      reset = 1'b0;

      // 1: preloaded frame, sink always ready
      p0 = pop_cnt; f0 = fd_cnt; a0 = acc_cnt;
      issue_frame(1'b1, 0);
      wait_done("t1");
      chk("t1_pops", pop_cnt - p0, NP);
      chk("t1_frame_done", fd_cnt - f0, 1);
      chk("t1_beats", acc_cnt - a0, NP + 11);
      $display("frame 1: %0d beats, %0d pops", acc_cnt - a0, pop_cnt - p0);

      // 2: sink ready one cycle in three
      ready_mode = 1; p0 = pop_cnt; f0 = fd_cnt;
      issue_frame(1'b1, 0);
      wait_done("t2");
      chk("t2_pops", pop_cnt - p0, NP);
      chk("t2_frame_done", fd_cnt - f0, 1);
      $display("frame 2 (stalled sink): %0d pops", pop_cnt - p0);

      // 3: gapped FIFO writes
      ready_mode = 0; gap_mode = 1; p0 = pop_cnt; f0 = fd_cnt;
      issue_frame(1'b0, 0);
      wait_done("t3");
      chk("t3_pops", pop_cnt - p0, NP);
      chk("t3_frame_done", fd_cnt - f0, 1);
      $display("frame 3 (gapped FIFO): %0d pops", pop_cnt - p0);

      // 4: two frames back to back
      gap_mode = 0; p0 = pop_cnt; f0 = fd_cnt;
      issue_frame(1'b1, 0);
      issue_frame(1'b1, NP);
      wait_done("t4");
      chk("t4_pops", pop_cnt - p0, 2 * NP);
      chk("t4_frame_done", fd_cnt - f0, 2);
      $display("frames 4-5 (back to back): %0d pops", pop_cnt - p0);

      // 5: reset once pixel 10 has been accepted
      a0 = acc_cnt;
      issue_frame(1'b1, 0);
      for (int n = 0; n < 500 && acc_cnt < a0 + 22; n++) begin
         @(negedge clock); #2;
      end
      chk("t5_reached_pixel10", 32'(acc_cnt >= a0 + 22), 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_reset_outputs", {20'd0, dout_valid, dout_sop, dout_eop, frame_done, in_rd_en, dout_data}, 32'd0);
      sb_q.delete();
      pend_q.delete();
      repeat (2) @(negedge clock);
      #2;
      chk("t5_reset_held", {20'd0, dout_valid, dout_sop, dout_eop, frame_done, in_rd_en, dout_data}, 32'd0);
      reset = 1'b0;
      p0 = pop_cnt; f0 = fd_cnt;
      issue_frame(1'b1, 100);
      wait_done("t5");
      chk("t5_pops", pop_cnt - p0, NP);
      chk("t5_frame_done", fd_cnt - f0, 1);
      $display("frame after reset: %0d pops", pop_cnt - p0);

      // 6: random sink backpressure, random write gaps, random pixels
      for (int f = 0; f < 3; f++) begin
         ready_mode = 2; gap_mode = $urandom_range(0, 1);
         p0 = pop_cnt; f0 = fd_cnt;
         issue_frame(1'b0, 0);
         wait_done("t6");
         chk("t6_pops", pop_cnt - p0, NP);
         chk("t6_frame_done", fd_cnt - f0, 1);
         $display("random frame %0d: gap_mode %0d, %0d pops", f, gap_mode, pop_cnt - p0);
      end

      chk("def_ctrl_count", def_seen, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
